// File: rtl/shift_packer_pkg.sv
// Shared types for the word packer: the two-state handshake FSM encoding.
package shift_packer_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_t;

endpackage

// File: rtl/shift_packer.sv
// Serial-to-parallel packer: collects IN_W-bit words into N_WORDS-word beats.
// The first word of a beat lands in the most significant occupied slot, and a
// flush emits a partial beat right-aligned with the unused upper bits zero.
module shift_packer
   import shift_packer_pkg::*;
#(
   parameter int IN_W    = 8,
   parameter int N_WORDS = 16,
   localparam int OUT_W  = IN_W * N_WORDS,
   localparam int CNT_W  = $clog2(N_WORDS + 1)
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready
);

   pack_state_t      state;
   logic [OUT_W-1:0] sreg;
   logic [CNT_W-1:0] count;

   logic             accept;
   logic [OUT_W-1:0] sreg_next;
   logic [CNT_W-1:0] count_next;
   logic             emit;

   // Handshake and next-beat contents: what the shifter and counter would hold
   // after this cycle's accept, and whether that closes the beat.
   always_comb begin
      in_ready   = (state == FILL) || out_ready;
      accept     = in_valid && in_ready;
      sreg_next  = accept ? {sreg[OUT_W-IN_W-1:0], in_data} : sreg;
      count_next = accept ? count + CNT_W'(1) : count;
      emit       = (count_next == CNT_W'(N_WORDS)) ||
                   (flush && (count_next != '0));
   end

   // FSM, shift register, word counter and registered beat outputs.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state     <= FILL;
         sreg      <= '0;
         count     <= '0;
         out_data  <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (emit) begin
                  state     <= HOLD;
                  out_data  <= sreg_next;
                  out_count <= count_next;
                  out_valid <= 1'b1;
                  sreg      <= '0;
                  count     <= '0;
               end else begin
                  sreg  <= sreg_next;
                  count <= count_next;
               end
            end
            HOLD: begin
               // Flush is ignored here; a word accepted during the handshake
               // starts the next beat so the input stream sees no bubble.
               if (out_ready) begin
                  state     <= FILL;
                  out_valid <= 1'b0;
                  sreg      <= '0;
                  count     <= '0;
                  if (accept) begin
                     sreg[IN_W-1:0] <= in_data;
                     count          <= CNT_W'(1);
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_packer.sv
// Self-checking bench for shift_packer (IN_W=8, N_WORDS=4): a queue-based
// model of the beat contents plus directed vectors with literal expectations.
module tb_shift_packer;

   logic        clock;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] out_data;
   logic [2:0]  out_count;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   shift_packer #(.IN_W(8), .N_WORDS(4)) dut (
      .clock    (clock),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .out_data (out_data),
      .out_count(out_count),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: words of the beat in progress kept in arrival order; a beat is
   // packed first-word-most-significant when it is full or flushed.
   logic [7:0]  cur[$];
   bit          m_hold = 0;
   logic [31:0] m_data = '0;
   int          m_cnt  = 0;

   always @(posedge clock) begin
      bit          acc;
      logic [31:0] p;
      if (!rst_n) begin
         cur.delete();
         m_hold = 0;
         m_data = '0;
         m_cnt  = 0;
      end else begin
         acc = in_valid && (!m_hold || out_ready);
         if (m_hold) begin
            if (out_ready) begin
               m_hold = 0;
               cur.delete();
               if (acc) cur.push_back(in_data);
            end
         end else begin
            if (acc) cur.push_back(in_data);
            if (cur.size() == 4 || (flush && cur.size() > 0)) begin
               p = '0;
               foreach (cur[i]) p = (p << 8) | 32'(cur[i]);
               m_data = p;
               m_cnt  = cur.size();
               m_hold = 1;
               cur.delete();
            end
         end
      end
   end

   // Every cycle: compare handshake and, while a beat is presented, its contents.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(!m_hold || out_ready));
         chk("out_valid", 32'(out_valid), 32'(m_hold));
         if (m_hold) begin
            chk("out_data", out_data, m_data);
            chk("out_count", 32'(out_count), 32'(m_cnt));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      rst_n  = 1'b1;
      chk_en = 1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Full beat, back-to-back, downstream ready
      out_ready = 1'b1;
      put(8'h11); put(8'h22); put(8'h33); put(8'h44);
      in_valid = 1'b0;
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_data", out_data, 32'h11223344);
      chk("t1_count", 32'(out_count), 32'd4);
      step();
      chk("t1_consumed", 32'(out_valid), 32'd0);

      // Full beat held under backpressure
      out_ready = 1'b0;
      put(8'h11); put(8'h22); put(8'h33); put(8'h44);
      in_data = 8'h99;
      for (int i = 0; i < 5; i++) begin
         chk("t2_in_ready", 32'(in_ready), 32'd0);
         chk("t2_data", out_data, 32'h11223344);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("t2_released", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      #1;
      chk("t2_fill_ready", 32'(in_ready), 32'd1);

      // Partial beat flush, then flush with nothing buffered
      put(8'hAA); put(8'hBB);
      in_valid = 1'b0;
      flush    = 1'b1;
      step();
      flush = 1'b0;
      chk("t3_data", out_data, 32'h0000AABB);
      chk("t3_count", 32'(out_count), 32'd2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      flush     = 1'b1;
      step();
      step();
      chk("t3_empty_flush", 32'(out_valid), 32'd0);
      flush = 1'b0;

      // Continuous stream, no stall
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         #0;
         chk("t4_in_ready", 32'(in_ready), 32'd1);
         step();
         if (i == 4) chk("t4_beat0", out_data, 32'h01020304);
         if (i == 8) chk("t4_beat1", out_data, 32'h05060708);
      end
      in_valid = 1'b0;
      step();

      // Reset mid-beat discards buffered words
      out_ready = 1'b0;
      put(8'hE1); put(8'hE2); put(8'hE3);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_data", out_data, 32'd0);
      chk("t5_count", 32'(out_count), 32'd0);
      rst_n = 1'b1;
      put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4);
      in_valid = 1'b0;
      chk("t5_beat", out_data, 32'hC1C2C3C4);
      out_ready = 1'b1;
      step();

      // Flush together with an accepted word
      out_ready = 1'b0;
      put(8'h01);
      in_data = 8'h5A;
      flush   = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("t6_data", out_data, 32'h0000015A);
      chk("t6_count", 32'(out_count), 32'd2);
      out_ready = 1'b1;
      step();

      // Handshake + accept + flush while full: flush only acts the cycle after
      out_ready = 1'b0;
      put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
      in_data   = 8'h77;
      flush     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("t7_no_flush_in_hold", 32'(out_valid), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      chk("t7_data", out_data, 32'h00000077);
      chk("t7_count", 32'(out_count), 32'd1);
      flush     = 1'b0;
      out_ready = 1'b1;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_packer.md
SHIFT_PACKER -- requirements
Module: shift_packer

Interface
REQ-001 SHALL have parameter IN_W, default 8, input word width in bits (>=1).
REQ-002 SHALL have parameter N_WORDS, default 16, words per output beat (>=2); OUT_W = IN_W*N_WORDS, CNT_W = $clog2(N_WORDS+1).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_data  input  IN_W  serial input word.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port flush  input  1  request to emit a partial beat.
REQ-009 SHALL have port out_data  output  OUT_W  packed output beat.
REQ-010 SHALL have port out_count  output  CNT_W  number of valid words in out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_count are valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the beat this cycle.

Function
REQ-013 SHALL implement two states: FILL (accumulating, out_valid=0) and HOLD (beat presented, out_valid=1).
REQ-014 SHALL accept a word exactly when in_valid && in_ready; in_ready = (state==FILL) || out_ready.
REQ-015 SHALL shift each accepted word into the LSB end (shift left by IN_W), so the first word of a beat ends up in the most significant occupied slot.
REQ-016 SHALL, in FILL, increment the word count per accepted word; on the accept that makes count==N_WORDS, go to HOLD next cycle with out_count=N_WORDS; latency is 1 cycle from the last accepted word to out_valid.
REQ-017 SHALL, in FILL with flush=1 and (count>0 or a word is accepted that cycle), go to HOLD with out_count = count plus any word accepted that cycle; out_data holds the words right-aligned with unused upper bits zero.
REQ-018 SHALL ignore flush when count==0 and no word is accepted, and in HOLD.
REQ-019 SHALL keep out_data and out_count stable while out_valid && !out_ready.
REQ-020 SHALL, in HOLD with out_ready=1, return to FILL with count 0 and the shift register cleared; if a word is accepted in the same cycle, it becomes word 1 of the next beat (count=1, no bubble).
REQ-021 SHALL, in HOLD with out_ready=1, in_valid=1, N_WORDS already reached and flush=1, apply REQ-020 and then REQ-017 next cycle only if flush is still asserted.
REQ-022 SHALL never drop, duplicate or reorder accepted words.

Reset
REQ-023 SHALL, when rst_n==0 at posedge, set state=FILL, count=0, out_data=0, out_count=0, out_valid=0; in_ready=1 while rst_n is high after reset.
REQ-024 SHALL discard any partial or held beat when reset is asserted mid-operation; the words are not emitted.

Structure
REQ-025 SHALL place the state enum (FILL, HOLD) in the shared package used by the matrix-calculator blocks; IN_W and N_WORDS remain module parameters.
REQ-026 SHALL use no sub-modules except an optional instance of the existing Counter for the word count; the shift path is local RTL.

Verification (bench IN_W=8, N_WORDS=4 plus a default 8/16 build)
REQ-027 SHALL cover: words 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> out_valid one cycle after 0x44, out_data=0x11223344, out_count=4.
REQ-028 SHALL cover: full beat with out_ready=0 for 5 cycles -> in_ready=0, out_data stable at 0x11223344, then one handshake and return to FILL.
REQ-029 SHALL cover: words 0xAA,0xBB then flush -> out_data=0x0000AABB, out_count=2; flush with count 0 -> no out_valid.
REQ-030 SHALL cover: continuous stream of 8 words with out_ready=1 -> beats 0x01020304 then 0x05060708, with no stall cycle on in_ready.
REQ-031 SHALL cover: rst_n=0 after 3 words -> outputs zero; next 4 words 0xC1..0xC4 -> out_data=0xC1C2C3C4.
REQ-032 SHALL cover: flush in the same cycle as accepted word 0x5A with count 1 (prior 0x01) -> out_data=0x0000015A, out_count=2.
